// File: rtl/alu_iter_if.sv
// Start/busy/done handshake and operand/result bus between the CPU controller and alu_iter.
interface alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             Zero;
    logic             busy;
    logic             done;

    modport master (output start, ALUOp, A, B, input C, Zero, busy, done);
    modport slave  (input start, ALUOp, A, B, output C, Zero, busy, done);
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add MULU and restoring DIVU/REMU.
// Latency 1 cycle (single ops) or WIDTH+1 (iterative); start ignored while busy. Divider enabled by ALU_DIV_EN.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] c_q;
    // hi: accumulator / partial remainder; lo: multiplier / dividend-then-quotient; mc: multiplicand / divisor
    logic [WIDTH-1:0] hi, lo, mc;
    logic [WIDTH-1:0] step_hi, step_lo, step_mc;
    logic [WIDTH-1:0] single_res;
    logic             is_iter;
    logic [WIDTH-1:0] final_res;

`ifdef ALU_DIV_EN
    logic [3:0]       op;
    logic [WIDTH:0]   rem_try;
    logic [WIDTH:0]   rem_diff;
`endif

    always_comb begin
        is_iter = (bus.ALUOp == OP_MULU);
`ifdef ALU_DIV_EN
        if (bus.ALUOp == OP_DIVU || bus.ALUOp == OP_REMU) is_iter = 1'b1;
`endif
    end

    always_comb begin
        single_res = bus.A;
        case (bus.ALUOp)
            OP_NOP:  single_res = bus.A;
            OP_ADD:  single_res = bus.A + bus.B;
            OP_SUB:  single_res = bus.A - bus.B;
            OP_AND:  single_res = bus.A & bus.B;
            OP_OR:   single_res = bus.A | bus.B;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLL:  single_res = bus.B << bus.A[SHW-1:0];
            OP_SRL:  single_res = bus.B >> bus.A[SHW-1:0];
            OP_SRA:  single_res = $unsigned($signed(bus.B) >>> bus.A[SHW-1:0]);
            default: single_res = bus.A;
        endcase
    end

    // One radix-2 iteration of whichever iterative op is in flight
    always_comb begin
        step_hi = hi + (lo[0] ? mc : '0);
        step_lo = lo >> 1;
        step_mc = mc << 1;
`ifdef ALU_DIV_EN
        rem_try  = {hi, lo[WIDTH-1]};
        rem_diff = rem_try - {1'b0, mc};
        if (op != OP_MULU) begin
            step_mc = mc;
            if (rem_try >= {1'b0, mc}) begin
                step_hi = rem_diff[WIDTH-1:0];
                step_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_try[WIDTH-1:0];
                step_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        final_res = step_hi;
`ifdef ALU_DIV_EN
        if (op == OP_DIVU) final_res = step_lo;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            c_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            mc    <= '0;
`ifdef ALU_DIV_EN
            op    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_iter) begin
                            state <= RUN;
                            cnt   <= '0;
                            hi    <= '0;
`ifdef ALU_DIV_EN
                            op    <= bus.ALUOp;
                            if (bus.ALUOp != OP_MULU) begin
                                lo <= bus.A;
                                mc <= bus.B;
                            end else begin
                                lo <= bus.B;
                                mc <= bus.A;
                            end
`else
                            lo    <= bus.B;
                            mc    <= bus.A;
`endif
                        end else begin
                            c_q   <= single_res;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    mc  <= step_mc;
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH-1)) begin
                        c_q   <= final_res;
                        state <= DONE;
                        cnt   <= '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.C    = c_q;
    assign bus.Zero = (c_q == '0);
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (WIDTH=32); divide expectations follow ALU_DIV_EN.
module tb_alu_iter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [31:0] prev_c;

    alu_iter_if #(.WIDTH(32)) bus ();

    alu_iter #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_c);
        bit iter;
        int early;
        bit held;
        iter = (op == 4'd10);
`ifdef ALU_DIV_EN
        if (op == 4'd11 || op == 4'd12) iter = 1'b1;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'h1357_9BDF;
        bus.ALUOp = 4'd1;
        if (iter) begin
            early = 0;
            held  = 1'b1;
            for (int i = 0; i < 32; i++) begin
                if (bus.done !== 1'b0) early++;
                if (bus.busy !== 1'b1) early++;
                if (bus.C !== prev_c) held = 1'b0;
                // stray start requests while busy must be dropped
                bus.start = i[0];
                bus.A     = $urandom;
                bus.B     = $urandom;
                @(posedge clk);
                #1;
            end
            chk({tag, " run_flags"}, 32'(early), 32'd0);
            chk({tag, " c_held"}, {31'd0, held}, 32'd1);
        end
        chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " busy_in_done"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, " C"}, bus.C, exp_c);
        chk({tag, " Zero"}, {31'd0, bus.Zero}, {31'd0, (exp_c == 32'd0)});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, " idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
        chk({tag, " C_kept"}, bus.C, exp_c);
        prev_c = exp_c;
    endtask

    initial begin
        int dones;
        n_chk  = 0;
        n_fail = 0;
        prev_c = 32'd0;
        bus.start = 1'b0;
        bus.ALUOp = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset C", bus.C, 32'd0);
        chk("reset Zero", {31'd0, bus.Zero}, 32'd1);
        chk("reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_ovf", 4'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        do_op("sub_zero", 4'd2, 32'd5, 32'd5, 32'd0);
        do_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);
        do_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0);
        do_op("sra", 4'd9, 32'd4, 32'h8000_0000, 32'hF800_0000);
        do_op("sll", 4'd7, 32'h0000_0124, 32'd1, 32'h0000_0010);
        do_op("srl", 4'd8, 32'd31, 32'h8000_0000, 32'd1);
        do_op("and", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        do_op("or", 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        do_op("nop", 4'd0, 32'h0000_1234, 32'hFFFF_0000, 32'h0000_1234);
        do_op("mulu", 4'd10, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
        do_op("mulu2", 4'd10, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);

        // Abort a multiply in its tenth RUN cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.ALUOp = 4'd10;
        bus.A     = 32'd12345;
        bus.B     = 32'd678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid C", bus.C, 32'd0);
        chk("rst_mid Zero", {31'd0, bus.Zero}, 32'd1);
        chk("rst_mid busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
        end
        chk("rst_mid no_done", 32'(dones), 32'd0);
        prev_c = 32'd0;

`ifdef ALU_DIV_EN
        do_op("divu", 4'd11, 32'd100, 32'd7, 32'd14);
        do_op("remu", 4'd12, 32'd100, 32'd7, 32'd2);
        do_op("divu_by0", 4'd11, 32'd100, 32'd0, 32'hFFFF_FFFF);
        do_op("remu_by0", 4'd12, 32'd100, 32'd0, 32'd100);
`else
        do_op("divu_undef", 4'd11, 32'd100, 32'd7, 32'd100);
        do_op("remu_undef", 4'd12, 32'd100, 32'd7, 32'd100);
`endif
        do_op("op13", 4'd13, 32'hCAFE_0001, 32'd9, 32'hCAFE_0001);
        do_op("op15", 4'd15, 32'hA5A5_5A5A, 32'd9, 32'hA5A5_5A5A);
        do_op("back_to_back", 4'd1, 32'd2, 32'd3, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
